// File: rtl/string_led_receiver.sv
// rtl/string_led_receiver.sv - string-LED serial line decoder with word FIFO and Wishbone slave
//
// Purpose: decodes a pulse-width coded string-LED line (MSB-first, 24-bit words)
//   into a word FIFO readable over a Wishbone slave port, with frame and
//   overflow status flags and a level interrupt.
// Ports:
//   wb_clk_i, wb_rst_i   clock, asynchronous active-high reset
//   wbs_*                Wishbone slave (cyc/stb/we/sel/adr/dat_i in; dat_o/ack_o out)
//   sin                  asynchronous serial line, idle low
//   irq                  registered level interrupt
module string_led_receiver #(
  parameter int FDEPTH = 8,   // word FIFO depth, power of two (>= 2)
  parameter int CSIZE  = 16   // pulse counter width (<= 32)
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  input  logic        sin,
  output logic        irq
);

  localparam int AW = $clog2(FDEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  logic              s1_q, s_q, sp_q;
  logic              ack_q, irq_q;
  logic [31:0]       dat_q;
  logic              en_q, ie_data_q, ie_frame_q, done_q, err_q, ovf_q;
  logic [CSIZE-1:0]  t_bit_q, t_rst_q, cnt_q;
  state_t            state_q;
  logic [4:0]        bitcnt_q;
  logic [23:0]       shreg_q;
  logic [23:0]       mem_q [FDEPTH];
  logic [AW-1:0]     wp_q, rp_q;
  logic [CW-1:0]     count_q, count_d;

  // Bus decode: a request is accepted only in a cycle where ack is low,
  // which also prevents back-to-back acks.
  logic        req, wr, rd;
  logic [1:0]  reg_sel;
  logic [31:0] wmask, rdata;
  assign req     = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr      = req & wbs_we_i;
  assign rd      = req & ~wbs_we_i;
  assign reg_sel = wbs_adr_i[3:2];
  assign wmask   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  logic wr_ctrl, wr_tbit, wr_trst;
  assign wr_ctrl = wr && (reg_sel == 2'd0);
  assign wr_tbit = wr && (reg_sel == 2'd1);
  assign wr_trst = wr && (reg_sel == 2'd2);

  // w1c clear strobes for CTRL[10:8]
  logic [2:0] w1c;
  assign w1c = wr_ctrl ? (wbs_dat_i[10:8] & wmask[10:8]) : 3'b000;

  // Edge detect on the synchronized line
  logic rise, fall;
  assign rise = s_q & ~sp_q;
  assign fall = ~s_q & sp_q;

  logic [CSIZE-1:0] cnt_inc;
  logic             bit_val;
  logic [23:0]      new_word;
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CSIZE'(1);
  assign bit_val  = (cnt_q >= t_bit_q);
  assign new_word = {shreg_q[22:0], bit_val};

  logic push, frame_end, done_set, err_set;
  assign push      = en_q && (state_q == HIGH) && fall && (bitcnt_q == 5'd23);
  assign frame_end = en_q && (state_q == LOW) && !rise && (cnt_q == t_rst_q);
  assign done_set  = frame_end && (bitcnt_q == 5'd0);
  assign err_set   = frame_end && (bitcnt_q != 5'd0);

  // A pop in the same cycle as a push to a full FIFO frees the slot first,
  // so the push is accepted and nothing overflows.
  logic empty, full, pop, push_ok, ovf_set;
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FDEPTH));
  assign pop     = rd && (reg_sel == 2'd3) && !empty;
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;
  assign count_d = count_q + CW'(push_ok) - CW'(pop);

  always_comb begin
    rdata = 32'd0;
    case (reg_sel)
      2'd0: rdata = {12'd0, 4'(count_q), 5'd0, ovf_q, err_q, done_q,
                     5'd0, ie_frame_q, ie_data_q, en_q};
      2'd1: rdata = 32'(t_bit_q);
      2'd2: rdata = 32'(t_rst_q);
      default: rdata = empty ? 32'd0 : {8'd0, mem_q[rp_q]};
    endcase
  end

  // FIFO storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem_q[wp_q] <= new_word;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      s1_q       <= 1'b0;
      s_q        <= 1'b0;
      sp_q       <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= 32'd0;
      irq_q      <= 1'b0;
      en_q       <= 1'b0;
      ie_data_q  <= 1'b0;
      ie_frame_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      t_bit_q    <= CSIZE'(20);
      t_rst_q    <= CSIZE'(200);
      cnt_q      <= '0;
      state_q    <= IDLE;
      bitcnt_q   <= 5'd0;
      shreg_q    <= 24'd0;
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
    end else begin
      s1_q  <= sin;
      s_q   <= s1_q;
      sp_q  <= s_q;

      ack_q <= req;
      dat_q <= rd ? rdata : 32'd0;

      if (wr_ctrl && wbs_sel_i[0]) {ie_frame_q, ie_data_q, en_q} <= wbs_dat_i[2:0];
      if (wr_tbit) t_bit_q <= (t_bit_q & ~wmask[CSIZE-1:0]) | (wbs_dat_i[CSIZE-1:0] & wmask[CSIZE-1:0]);
      if (wr_trst) t_rst_q <= (t_rst_q & ~wmask[CSIZE-1:0]) | (wbs_dat_i[CSIZE-1:0] & wmask[CSIZE-1:0]);

      // Set wins over a coincident w1c clear.
      done_q <= (done_q & ~w1c[0]) | done_set;
      err_q  <= (err_q  & ~w1c[1]) | err_set;
      ovf_q  <= (ovf_q  & ~w1c[2]) | ovf_set;

      if (push_ok) wp_q <= wp_q + AW'(1);
      if (pop)     rp_q <= rp_q + AW'(1);
      count_q <= count_d;

      irq_q <= (ie_data_q & !empty) | (ie_frame_q & done_q);

      if (!en_q) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        bitcnt_q <= 5'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise) begin
              state_q <= HIGH;
              cnt_q   <= CSIZE'(1);
            end
          end
          HIGH: begin
            if (fall) begin
              shreg_q  <= new_word;
              bitcnt_q <= (bitcnt_q == 5'd23) ? 5'd0 : bitcnt_q + 5'd1;
              cnt_q    <= CSIZE'(1);
              state_q  <= LOW;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          LOW: begin
            if (rise) begin
              state_q <= HIGH;
              cnt_q   <= CSIZE'(1);
            end else if (cnt_q == t_rst_q) begin
              // Frame end: a partial word is discarded here.
              state_q  <= IDLE;
              cnt_q    <= '0;
              bitcnt_q <= 5'd0;
              shreg_q  <= 24'd0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq       = irq_q;

endmodule

// File: doc/string_led_receiver.md
STRING_LED_RECEIVER -- requirements
Module: string_led_receiver

Interface
REQ-001 Parameters SHALL be: FDEPTH (default 8) = word FIFO depth, power of two; CSIZE (default 16) = pulse counter width.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset (wb_rst_i).
REQ-003 Ports SHALL be, in this order:
- wb_clk_i  in  1  system and Wishbone clock
- wb_rst_i  in  1  asynchronous active-high reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  Wishbone write enable
- wbs_sel_i  in  4  Wishbone byte selects
- wbs_adr_i  in  32  Wishbone address; only [3:2] decoded
- wbs_dat_i  in  32  Wishbone write data
- wbs_dat_o  out  32  Wishbone read data
- wbs_ack_o  out  1  Wishbone acknowledge
- sin  in  1  asynchronous serial string-LED line; idle low
- irq  out  1  level interrupt

Function
REQ-004 sin SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized value (s).
REQ-005 Registers SHALL be:
- adr[3:2]=0 CTRL/STAT: [0] EN rw, [1] IE_DATA rw, [2] IE_FRAME rw, [8] FRAME_DONE w1c, [9] FRAME_ERR w1c, [10] OVERFLOW w1c, [19:16] fifo count ro
- adr[3:2]=1 T_BIT: [CSIZE-1:0] rw
- adr[3:2]=2 T_RST: [CSIZE-1:0] rw
- adr[3:2]=3 DATA: ro, [23:0] oldest word
REQ-006 Writes SHALL honour wbs_sel_i per byte; unused bits read 0.
REQ-007 wbs_ack_o SHALL pulse for exactly one cycle, the cycle after cyc&stb&!ack; no back-to-back ack.
REQ-008 A DATA read SHALL return the FIFO head and pop it in the ack cycle; a read of an empty FIFO returns 0 and pops nothing.
REQ-009 The decoder FSM SHALL have states IDLE, HIGH, LOW; EN=0 forces IDLE, clears cnt and the bit counter, and leaves FIFO contents.
REQ-010 IDLE: on s rising edge -> HIGH, cnt=1.
REQ-011 HIGH: cnt increments each cycle s=1, saturating at all-ones; on s falling edge shift bit (cnt >= T_BIT ? 1 : 0) MSB-first into a 24-bit register, bit counter +1, cnt=1, -> LOW.
REQ-012 LOW: cnt increments, saturating; s rising edge -> HIGH, cnt=1; cnt == T_RST -> frame end, -> IDLE.
REQ-013 When the 24th bit is shifted, the word SHALL be pushed into the FIFO in the same cycle and the bit counter wraps to 0.
REQ-014 Push while FIFO is full SHALL drop the word and set OVERFLOW; FIFO contents are unchanged.
REQ-015 Simultaneous push and pop SHALL both occur; the count is unchanged, including when full (pop frees the slot).
REQ-016 Frame end with bit counter = 0 SHALL set FRAME_DONE; with bit counter != 0 it SHALL discard the partial word, clear the bit counter, and set FRAME_ERR.
REQ-017 A w1c write coinciding with a set event for the same flag SHALL leave the flag set.
REQ-018 irq SHALL equal (IE_DATA & fifo_count!=0) | (IE_FRAME & FRAME_DONE), registered.
REQ-019 Decode latency: sin edge -> FSM reaction 3 cycles (2 sync + 1 edge detect).

Reset
REQ-020 On wb_rst_i: FSM=IDLE; cnt, bit counter, shift register, FIFO pointers and count =0; CTRL =0; T_BIT=20; T_RST=200; wbs_ack_o=0; wbs_dat_o=0; irq=0; synchronizer flops=0.
REQ-021 Reset asserted mid-frame SHALL abort immediately; no word is pushed and no flag is set on release.

Verification
REQ-022 EN=1, T_BIT=20, T_RST=200; send 0xA5C3F0 MSB-first, 50-cycle bits (high 30 = 1, high 10 = 0), then low 250 -> DATA reads 0x00A5C3F0, FRAME_DONE=1, count 0 after the read.
REQ-023 Send 10 bits, then low 250 -> FRAME_ERR=1, FIFO empty; the next full 24-bit word decodes correctly.
REQ-024 Send 9 words, no reads -> count=8, OVERFLOW=1, first 8 words read back in order, 9th absent.
REQ-025 FIFO full; read DATA in the same cycle a 24th bit completes -> count stays 8, OVERFLOW=0.
REQ-026 IE_DATA=1 -> irq rises 1 cycle after the first push and falls 1 cycle after the last pop; read of empty DATA -> 0x00000000, one-cycle ack.
REQ-027 Assert wb_rst_i after 12 bits -> all registers at reset values, count=0, irq=0.
